// File: rtl/sa_pkg.sv
// Shared types and helpers for the NxN output-stationary systolic matmul engine.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // True when skew step t, offset by lane index off, lands inside an operand row of length n.
  function automatic logic in_window(input int t, input int off, input int n);
    return (t >= off) && ((t - off) < n);
  endfunction

endpackage

// File: rtl/sa_matmul_engine_if.sv
// Load, control and result ports of the systolic matmul engine.
// Valid/ready: a transfer happens on a rising edge where both VALID and READY are high;
// the sender holds its payload stable while VALID is high and READY is low.
interface sa_matmul_engine_if #(
  parameter int N    = 8,
  parameter int DW   = 16,
  parameter int ACCW = 32
);
  localparam int RW = $clog2(N);

  logic            LD_VALID;
  logic            LD_READY;
  logic            LD_SEL;
  logic [RW-1:0]   LD_ROW;
  logic [N*DW-1:0] LD_DATA;
  logic            START;
  logic            BUSY;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [RW-1:0]     OUT_ROW;
  logic [N*ACCW-1:0] OUT_DATA;
  logic              DONE;

  modport master (
    output LD_VALID, LD_SEL, LD_ROW, LD_DATA, START, OUT_READY,
    input  LD_READY, BUSY, OUT_VALID, OUT_ROW, OUT_DATA, DONE
  );

  modport slave (
    input  LD_VALID, LD_SEL, LD_ROW, LD_DATA, START, OUT_READY,
    output LD_READY, BUSY, OUT_VALID, OUT_ROW, OUT_DATA, DONE
  );

endinterface

// File: rtl/sa_pe.sv
// One multiply-accumulate cell: registers a rightwards and b downwards, accumulates a*b.
module sa_pe #(
  parameter int DW   = 16,
  parameter int ACCW = 32
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   EN,
  input  logic                   CLR,
  input  logic signed [DW-1:0]   a_in,
  input  logic signed [DW-1:0]   b_in,
  output logic signed [DW-1:0]   a_out,
  output logic signed [DW-1:0]   b_out,
  output logic signed [ACCW-1:0] acc
);

  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] prod_ext;

  assign prod = a_in * b_in;

  // Full-width signed product, sign-extended or truncated to the accumulator width.
  generate
    if (ACCW > 2*DW) begin : g_sext
      assign prod_ext = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
    end else begin : g_trunc
      assign prod_ext = prod[ACCW-1:0];
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (CLR) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (EN) begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/sa_matmul_engine.sv
// NxN output-stationary systolic engine computing Y = X * W: operand buffers,
// skew feeder, PE mesh and the load/compute/drain controller.
module sa_matmul_engine
  import sa_pkg::*;
#(
  parameter int N    = 8,
  parameter int DW   = 16,
  parameter int ACCW = 32
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  sa_matmul_engine_if.slave    bus,
  output state_t               dbg_state
);

  localparam int RW     = $clog2(N);
  localparam int TW     = $clog2(3*N-2);
  localparam int T_LAST = 3*N-3;

  state_t        state_q, state_d;
  logic [TW-1:0] t_q;
  logic [RW-1:0] r_q;
  logic          done_q;

  logic signed [DW-1:0] x_buf [N][N];
  logic signed [DW-1:0] w_buf [N][N];

  logic fire_ld, start_go, out_hs, last_hs, pe_en;

  assign fire_ld  = bus.LD_VALID && (state_q == IDLE);
  assign start_go = bus.START && (state_q == IDLE);
  assign out_hs   = (state_q == DRAIN) && bus.OUT_READY;
  assign last_hs  = out_hs && (r_q == RW'(N-1));
  assign pe_en    = (state_q == COMPUTE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.START)             state_d = COMPUTE;
      COMPUTE: if (t_q == TW'(T_LAST))    state_d = DRAIN;
      DRAIN:   if (last_hs)               state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // t sits at 0 outside COMPUTE so a fresh job always begins at skew step 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      t_q    <= '0;
      r_q    <= '0;
      done_q <= 1'b0;
    end else begin
      if ((state_q == COMPUTE) && (t_q != TW'(T_LAST))) t_q <= t_q + 1'b1;
      else                                             t_q <= '0;
      if (state_q != DRAIN)  r_q <= '0;
      else if (last_hs)      r_q <= '0;
      else if (out_hs)       r_q <= r_q + 1'b1;
      done_q <= last_hs;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          x_buf[i][k] <= '0;
          w_buf[i][k] <= '0;
        end
      end
    end else if (fire_ld) begin
      for (int k = 0; k < N; k++) begin
        if (!bus.LD_SEL) x_buf[bus.LD_ROW][k] <= bus.LD_DATA[k*DW +: DW];
        else             w_buf[bus.LD_ROW][k] <= bus.LD_DATA[k*DW +: DW];
      end
    end
  end

  // Skew feeder: row lane i sees X[i][t-i], column lane j sees W[t-j][j], zero outside the window.
  logic signed [DW-1:0] a_edge [N];
  logic signed [DW-1:0] b_edge [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_edge[i] = '0;
      b_edge[i] = '0;
      if (in_window(int'(t_q), i, N)) begin
        a_edge[i] = x_buf[i][RW'(int'(t_q) - i)];
        b_edge[i] = w_buf[RW'(int'(t_q) - i)][i];
      end
    end
  end

  logic signed [DW-1:0]   a_out [N][N];
  logic signed [DW-1:0]   b_out [N][N];
  logic signed [ACCW-1:0] acc   [N][N];

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic signed [DW-1:0] a_in_w, b_in_w;
      if (gj == 0) begin : g_a_edge
        assign a_in_w = a_edge[gi];
      end else begin : g_a_mesh
        assign a_in_w = a_out[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign b_in_w = b_edge[gj];
      end else begin : g_b_mesh
        assign b_in_w = b_out[gi-1][gj];
      end
      sa_pe #(.DW(DW), .ACCW(ACCW)) u_pe (
        .CLK   (CLK),
        .RST_N (RST_N),
        .EN    (pe_en),
        .CLR   (start_go),
        .a_in  (a_in_w),
        .b_in  (b_in_w),
        .a_out (a_out[gi][gj]),
        .b_out (b_out[gi][gj]),
        .acc   (acc[gi][gj])
      );
    end
  end

  always_comb begin
    bus.OUT_DATA = '0;
    if (state_q == DRAIN) begin
      for (int j = 0; j < N; j++) bus.OUT_DATA[j*ACCW +: ACCW] = acc[r_q][j];
    end
  end

  assign bus.OUT_VALID = (state_q == DRAIN);
  assign bus.OUT_ROW   = r_q;
  assign bus.LD_READY  = (state_q == IDLE);
  assign bus.BUSY      = (state_q != IDLE);
  assign bus.DONE      = done_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_sa_matmul_engine.sv
// Directed bench for sa_matmul_engine: table of operand patterns with hand-computed Y,
// plus sequences for backpressure, ignored inputs during compute and reset mid-drain.
module tb_sa_matmul_engine;
  import sa_pkg::*;

  localparam int N    = 8;
  localparam int DW   = 16;
  localparam int ACCW = 32;
  localparam int RW   = $clog2(N);
  localparam int LAT  = 3*N-2;
  localparam int RWID = N*ACCW;
  localparam int QW   = RW + RWID;

  typedef struct {
    logic            ident;
    logic [DW-1:0]   x_val;
    logic [DW-1:0]   w_val;
    logic [ACCW-1:0] exp_el;
  } vec_t;

  logic   CLK = 1'b0;
  logic   RST_N = 1'b0;
  state_t dbg_state;

  sa_matmul_engine_if #(.N(N), .DW(DW), .ACCW(ACCW)) bus ();

  sa_matmul_engine #(.N(N), .DW(DW), .ACCW(ACCW)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [QW-1:0] exp_q[$];
  vec_t vt[6];

  task automatic check(input string name, input logic [RWID-1:0] act, input logic [RWID-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [N*DW-1:0] fill_row(input logic [DW-1:0] v);
    logic [N*DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [RWID-1:0] exp_row(input vec_t v, input int r);
    logic [RWID-1:0] d;
    for (int j = 0; j < N; j++) d[j*ACCW +: ACCW] = v.ident ? ACCW'(N*r + j) : v.exp_el;
    return d;
  endfunction

  task automatic load_row(input logic sel, input int row, input logic [N*DW-1:0] data);
    bus.LD_VALID = 1'b1;
    bus.LD_SEL   = sel;
    bus.LD_ROW   = RW'(row);
    bus.LD_DATA  = data;
    tick();
    bus.LD_VALID = 1'b0;
  endtask

  task automatic load_vec(input vec_t v);
    logic [N*DW-1:0] xr, wr;
    for (int i = 0; i < N; i++) begin
      if (v.ident) begin
        xr = '0;
        xr[i*DW +: DW] = DW'(1);
        for (int j = 0; j < N; j++) wr[j*DW +: DW] = DW'(N*i + j);
      end else begin
        xr = fill_row(v.x_val);
        wr = fill_row(v.w_val);
      end
      load_row(1'b0, i, xr);
      load_row(1'b1, i, wr);
    end
  endtask

  task automatic push_expected(input vec_t v);
    for (int r = 0; r < N; r++) exp_q.push_back({RW'(r), exp_row(v, r)});
  endtask

  // Pulses START, then counts edges until OUT_VALID; optionally pokes START/LD_VALID mid-compute.
  task automatic run_start(input int poke_at, output int lat);
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    lat = 0;
    while (!bus.OUT_VALID && lat < 200) begin
      if (lat == poke_at) begin
        bus.START    = 1'b1;
        bus.LD_VALID = 1'b1;
        bus.LD_SEL   = 1'b0;
        bus.LD_ROW   = '0;
        bus.LD_DATA  = fill_row(16'h7FFF);
        check("ld_ready_in_compute", RWID'(bus.LD_READY), '0);
        check("busy_in_compute", RWID'(bus.BUSY), RWID'(1));
        check("state_in_compute", RWID'(dbg_state), RWID'(COMPUTE));
      end
      tick();
      bus.START    = 1'b0;
      bus.LD_VALID = 1'b0;
      lat++;
    end
  endtask

  task automatic drain(input int stall_row, input int stall_n);
    int hs = 0;
    int stalled = 0;
    int cyc = 0;
    logic [QW-1:0] e;
    bus.OUT_READY = 1'b0;
    while (hs < N && cyc < 400) begin
      if (bus.OUT_VALID) begin
        e = (exp_q.size() != 0) ? exp_q[0] : '0;
        check("out_row", RWID'(bus.OUT_ROW), RWID'(e[QW-1 -: RW]));
        check("out_data", bus.OUT_DATA, e[RWID-1:0]);
        check("done_low_in_drain", RWID'(bus.DONE), '0);
        if (int'(bus.OUT_ROW) == stall_row && stalled < stall_n) begin
          bus.OUT_READY = 1'b0;
          stalled++;
        end else begin
          bus.OUT_READY = 1'b1;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          hs++;
        end
      end else begin
        bus.OUT_READY = 1'b0;
      end
      tick();
      cyc++;
    end
    bus.OUT_READY = 1'b0;
    check("handshakes", RWID'(hs), RWID'(N));
    check("done_pulse", RWID'(bus.DONE), RWID'(1));
    check("busy_after_drain", RWID'(bus.BUSY), '0);
    check("ld_ready_after_drain", RWID'(bus.LD_READY), RWID'(1));
    tick();
    check("done_single_cycle", RWID'(bus.DONE), '0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    int hs;
    int cyc;
    logic [QW-1:0] e;

    vt[0] = '{1'b1, 16'h0000, 16'h0000, 32'h0000_0000};
    vt[1] = '{1'b0, 16'hFFFF, 16'h0002, 32'hFFFF_FFF0};
    vt[2] = '{1'b0, 16'h7FFF, 16'h7FFF, 32'hFFF8_0008};
    vt[3] = '{1'b0, 16'h0003, 16'hFFFE, 32'hFFFF_FFD0};
    vt[4] = '{1'b0, 16'h8000, 16'h8000, 32'h0000_0000};
    vt[5] = '{1'b0, 16'h8000, 16'h7FFF, 32'h0004_0000};

    bus.LD_VALID  = 1'b0;
    bus.LD_SEL    = 1'b0;
    bus.LD_ROW    = '0;
    bus.LD_DATA   = '0;
    bus.START     = 1'b0;
    bus.OUT_READY = 1'b0;

    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", RWID'(bus.BUSY), '0);
    check("rst_out_valid", RWID'(bus.OUT_VALID), '0);
    check("rst_done", RWID'(bus.DONE), '0);
    check("rst_out_row", RWID'(bus.OUT_ROW), '0);
    check("rst_out_data", bus.OUT_DATA, '0);
    RST_N = 1'b1;
    tick();
    check("rst_ld_ready", RWID'(bus.LD_READY), RWID'(1));

    // Table pass: each pattern loaded, computed and drained.
    for (int v = 0; v < 6; v++) begin
      load_vec(vt[v]);
      push_expected(vt[v]);
      run_start(-1, lat);
      check("latency", RWID'(lat), RWID'(LAT));
      drain((v == 0 || v == 2) ? 3 : -1, 5);
    end

    // START / LD_VALID poked mid-compute must be ignored; rerun without reload matches.
    load_vec(vt[3]);
    push_expected(vt[3]);
    run_start(5, lat);
    check("latency_poked", RWID'(lat), RWID'(LAT));
    drain(-1, 0);
    push_expected(vt[3]);
    run_start(-1, lat);
    check("latency_rerun", RWID'(lat), RWID'(LAT));
    drain(-1, 0);

    // Reset while row 3 is presented aborts the job.
    load_vec(vt[0]);
    push_expected(vt[0]);
    run_start(-1, lat);
    hs = 0;
    cyc = 0;
    bus.OUT_READY = 1'b1;
    while (hs < 3 && cyc < 100) begin
      if (bus.OUT_VALID) begin
        e = exp_q.pop_front();
        check("pre_rst_data", bus.OUT_DATA, e[RWID-1:0]);
        hs++;
      end
      tick();
      cyc++;
    end
    bus.OUT_READY = 1'b0;
    check("pre_rst_row3", RWID'(bus.OUT_ROW), RWID'(3));
    RST_N = 1'b0;
    #1;
    check("mid_rst_out_valid", RWID'(bus.OUT_VALID), '0);
    check("mid_rst_busy", RWID'(bus.BUSY), '0);
    check("mid_rst_done", RWID'(bus.DONE), '0);
    exp_q.delete();
    tick();
    tick();
    RST_N = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("post_rst_done", RWID'(bus.DONE), '0);
      check("post_rst_ld_ready", RWID'(bus.LD_READY), RWID'(1));
    end
    // Buffers were cleared, so a fresh job yields all-zero rows.
    for (int r = 0; r < N; r++) exp_q.push_back({RW'(r), {RWID{1'b0}}});
    run_start(-1, lat);
    check("latency_post_rst", RWID'(lat), RWID'(LAT));
    drain(-1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
